wb_regfile: RTL



---
 rtl/wb_regfile_pkg.sv | 23 ++
 rtl/wb_regfile_if.sv | 39 +++
 rtl/wb_regfile_hilo_reg.sv | 48 ++++
 rtl/wb_regfile.sv | 64 ++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared widths, constants and helpers for the write-back register file slice.
// The pipeline's shared defines are mirrored here so every file sees the same values.
package wb_regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_W      = 32;
  localparam int REG_NUM    = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_W-1:0]      reg_word_t;

  localparam reg_word_t ZERO_WORD    = '0;
  localparam reg_addr_t NOP_REG_ADDR = '0;
  localparam logic      RST_ENABLE   = 1'b1;
  localparam logic      WRITE_ENABLE = 1'b1;
  localparam logic      READ_ENABLE  = 1'b1;

  // $0 is hardwired: no read port may ever observe a value there.
  function automatic logic is_zero_reg(input reg_addr_t addr);
    return addr == NOP_REG_ADDR;
  endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// MEM-WB write-back bundle plus the ID read ports and EX/MEM state views.
// master = pipeline side, slave = register file.
interface wb_regfile_if;
  import wb_regfile_pkg::*;

  reg_addr_t wb_wd;
  logic      wb_wreg;
  reg_word_t wb_wdata;
  logic      wb_whilo;
  reg_word_t wb_hi;
  reg_word_t wb_lo;
  logic      wb_llbit_we;
  logic      wb_llbit_value;
  logic      flush;
  logic      re1;
  reg_addr_t raddr1;
  reg_word_t rdata1;
  logic      re2;
  reg_addr_t raddr2;
  reg_word_t rdata2;
  reg_word_t hi_o;
  reg_word_t lo_o;
  logic      llbit_o;

  modport master (
    output wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo,
    output wb_llbit_we, wb_llbit_value, flush,
    output re1, raddr1, re2, raddr2,
    input  rdata1, rdata2, hi_o, lo_o, llbit_o
  );

  modport slave (
    input  wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo,
    input  wb_llbit_we, wb_llbit_value, flush,
    input  re1, raddr1, re2, raddr2,
    output rdata1, rdata2, hi_o, lo_o, llbit_o
  );

endinterface

// File: rtl/wb_regfile_hilo_reg.sv
// HI/LO pair and the LL/SC link bit; flush outranks a pending LLbit write.
module hilo_reg
  import wb_regfile_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      whilo,
  input  reg_word_t wr_hi,
  input  reg_word_t wr_lo,
  input  logic      llbit_we,
  input  logic      llbit_value,
  input  logic      flush,
  output reg_word_t hi,
  output reg_word_t lo,
  output logic      llbit
);

  reg_word_t hi_reg;
  reg_word_t lo_reg;
  logic      llbit_reg;
  logic      llbit_next;

  // The bypassed view and the next stored value follow the same priority chain.
  always_comb begin
    llbit_next = llbit_reg;
    if (rst == RST_ENABLE || flush) begin
      llbit_next = 1'b0;
    end else if (llbit_we == WRITE_ENABLE) begin
      llbit_next = llbit_value;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      hi_reg <= ZERO_WORD;
      lo_reg <= ZERO_WORD;
    end else if (whilo == WRITE_ENABLE) begin
      hi_reg <= wr_hi;
      lo_reg <= wr_lo;
    end
    llbit_reg <= llbit_next;
  end

  assign hi    = hi_reg;
  assign lo    = lo_reg;
  assign llbit = llbit_next;

endmodule

// File: rtl/wb_regfile.sv
// Write-back state sink: 32x32 GPR file with two write-first bypassed read
// ports, plus HI/LO and LLbit held in hilo_reg.
module wb_regfile
  import wb_regfile_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  wb_regfile_if.slave    bus
);

  // Entry $0 is never stored; reads of it are forced to zero below.
  reg_word_t gpr_reg [1:REG_NUM-1];

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      for (int i = 1; i < REG_NUM; i++) begin
        gpr_reg[i] <= ZERO_WORD;
      end
    end else if (bus.wb_wreg == WRITE_ENABLE && !is_zero_reg(bus.wb_wd)) begin
      gpr_reg[bus.wb_wd] <= bus.wb_wdata;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic      en;
      reg_addr_t addr;
      reg_word_t data;

      assign en   = (gi == 0) ? bus.re1    : bus.re2;
      assign addr = (gi == 0) ? bus.raddr1 : bus.raddr2;

      always_comb begin
        data = ZERO_WORD;
        if (rst == RST_ENABLE || en != READ_ENABLE || is_zero_reg(addr)) begin
          data = ZERO_WORD;
        end else if (bus.wb_wreg == WRITE_ENABLE && bus.wb_wd == addr) begin
          data = bus.wb_wdata;
        end else begin
          data = gpr_reg[addr];
        end
      end
    end
  endgenerate

  assign bus.rdata1 = g_rd[0].data;
  assign bus.rdata2 = g_rd[1].data;

  hilo_reg u_hilo_reg (
    .clk         (clk),
    .rst         (rst),
    .whilo       (bus.wb_whilo),
    .wr_hi       (bus.wb_hi),
    .wr_lo       (bus.wb_lo),
    .llbit_we    (bus.wb_llbit_we),
    .llbit_value (bus.wb_llbit_value),
    .flush       (bus.flush),
    .hi          (bus.hi_o),
    .lo          (bus.lo_o),
    .llbit       (bus.llbit_o)
  );

endmodule
